// File: rtl/pong_pkg.sv
// pong_pkg: playfield geometry, ball FSM states and span-overlap helper shared by paddle and ball logic
package pong_pkg;
    localparam int ACTIVE_ROWS = 480;
    localparam int ACTIVE_COLS = 640;
    localparam int PADDLE_WIDTH = 16;
    localparam int PADDLE_HEIGHT = 64;
    localparam int LEFT_PADDLE_X = PADDLE_WIDTH / 2;
    localparam int RIGHT_PADDLE_X = ACTIVE_COLS - 1 - 3 * PADDLE_WIDTH / 2;
    localparam int XW = $clog2(ACTIVE_COLS);
    localparam int YW = $clog2(ACTIVE_ROWS);
    localparam int CW = XW + 1;
    typedef logic [CW-1:0] coord_t;
    typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAME_OVER} ball_state_t;
    // one extra bit so a+al and b+bl never wrap
    function automatic logic spans_overlap(input coord_t a, input coord_t al, input coord_t b, input coord_t bl);
        return (a + al > b) && (a < b + bl);
    endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: free-running CLKS_PER_MOVE counter producing a one-clk move tick strobe
module move_tick_gen #(
    parameter int CLKS_PER_MOVE = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_MOVE + 1);
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(CLKS_PER_MOVE);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall/paddle bounces, scoring and serve FSM with raster hit output
module ball_engine
    import pong_pkg::*;
#(
    parameter int CLKS_PER_MOVE = 250_000,
    parameter int SIZE = 8,
    parameter int SERVE_DELAY_MOVES = 120,
    parameter int WIN_SCORE = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [YW-1:0] row,
    input  logic [XW-1:0] col,
    input  logic [XW-1:0] left_pos,
    input  logic [XW-1:0] right_pos,
    output logic          ball_present,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic [3:0]    score_left,
    output logic [3:0]    score_right,
    output logic          point_pulse
);
    localparam logic [XW-1:0] CX = XW'(ACTIVE_COLS / 2 - SIZE / 2);
    localparam logic [YW-1:0] CY = YW'(ACTIVE_ROWS / 2 - SIZE / 2);
    localparam coord_t SZ = coord_t'(SIZE);
    localparam coord_t PH = coord_t'(PADDLE_HEIGHT);
    localparam int SW = $clog2(SERVE_DELAY_MOVES + 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY_MOVES - 1);
    ball_state_t state;
    logic tick, dx_neg, dy_neg, dy_toggle, y_top, y_bot, hit_l, hit_r, out_l, out_r, move_left;
    logic [SW-1:0] serve_cnt;
    logic [3:0] next_score;
    coord_t xe, ye;
    move_tick_gen #(.CLKS_PER_MOVE(CLKS_PER_MOVE)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != GAME_OVER),
        .tick (tick)
    );
    always_comb begin
        xe = coord_t'(ball_x);
        ye = coord_t'(ball_y);
        y_top = dy_neg && ball_y == '0;
        y_bot = !dy_neg && ye == coord_t'(ACTIVE_ROWS - SIZE);
        hit_l = dx_neg && xe == coord_t'(LEFT_PADDLE_X + PADDLE_WIDTH)
                && spans_overlap(ye, SZ, coord_t'(left_pos), PH);
        hit_r = !dx_neg && xe + SZ == coord_t'(RIGHT_PADDLE_X)
                && spans_overlap(ye, SZ, coord_t'(right_pos), PH);
        out_l = dx_neg && ball_x == '0;
        out_r = !dx_neg && xe == coord_t'(ACTIVE_COLS - SIZE);
        move_left = (dx_neg && !hit_l) || hit_r;
        next_score = (dx_neg ? score_right : score_left) + 4'd1;
        ball_present = state != GAME_OVER && spans_overlap(coord_t'(row), coord_t'(1), ye, SZ)
                       && spans_overlap(coord_t'(col), coord_t'(1), xe, SZ);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= SERVE;
            ball_x <= CX;
            ball_y <= CY;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            dy_toggle <= 1'b0;
            score_left <= '0;
            score_right <= '0;
            point_pulse <= 1'b0;
            serve_cnt <= '0;
        end else begin
            point_pulse <= 1'b0;
            unique case (state)
                SERVE: if (tick) begin
                    serve_cnt <= serve_cnt == SERVE_LAST ? '0 : serve_cnt + SW'(1);
                    if (serve_cnt == SERVE_LAST) state <= PLAY;
                end
                PLAY: if (tick) begin
                    ball_y <= y_top ? YW'(1) : (y_bot || dy_neg) ? ball_y - YW'(1) : ball_y + YW'(1);
                    dy_neg <= (dy_neg && !y_top) || y_bot;
                    dx_neg <= hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg;
                    if (out_l || out_r) state <= SCORED;
                    else ball_x <= move_left ? ball_x - XW'(1) : ball_x + XW'(1);
                end
                // dx already points at the loser, so it is kept for the serve
                SCORED: begin
                    if (dx_neg) score_right <= next_score;
                    else score_left <= next_score;
                    point_pulse <= 1'b1;
                    ball_x <= CX;
                    ball_y <= CY;
                    dy_toggle <= !dy_toggle;
                    dy_neg <= !dy_toggle;
                    serve_cnt <= '0;
                    state <= next_score == 4'(WIN_SCORE) ? GAME_OVER : SERVE;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized stimulus against a cycle-level behavioural model of the ball rules
module tb_ball_engine;
    localparam int CPM = 2, SDM = 4, SZ = 8, WIN = 9, ROWS = 480, COLS = 640;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [8:0] row;
    logic [9:0] col, left_pos, right_pos;
    logic ball_present, point_pulse;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_left, score_right;
    int vectors = 0, miscompares = 0;
    bit manual = 1'b0;
    int pmode = 0, lp_fix = 200, rp_fix = 400, man_row = 0, man_col = 0;
    int n, mx, my, mdx, mdy, sl, sr, serve_ticks, play_ticks, pending;
    bit tog, serving, over, mpp;

    ball_engine #(.CLKS_PER_MOVE(CPM), .SERVE_DELAY_MOVES(SDM)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .left_pos(left_pos), .right_pos(right_pos),
        .ball_present(ball_present), .ball_x(ball_x), .ball_y(ball_y),
        .score_left(score_left), .score_right(score_right), .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampv(int v, int lo, int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    function automatic bit overlaps(int y, int pos);
        return y + SZ > pos && y < pos + 64;
    endfunction

    function automatic bit in_play();
        return !serving && !over && pending == 0;
    endfunction

    // model: ticks every CPM+1 clocks counted from reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; mx = 316; my = 236; mdx = 1; mdy = 1; tog = 0; sl = 0; sr = 0; mpp = 0;
            serving = 1; over = 0; pending = 0; serve_ticks = 0; play_ticks = 0;
        end else begin
            int ny, ndy;
            bit tick;
            n++;
            tick = n % (CPM + 1) == 0;
            mpp = 0;
            if (over) begin
            end else if (pending != 0) begin
                if (pending == 1) sl++; else sr++;
                mpp = 1; mx = 316; my = 236;
                mdx = pending == 1 ? 1 : -1;
                tog = !tog; mdy = tog ? -1 : 1;
                serve_ticks = 0; play_ticks = 0; pending = 0;
                over = sl == WIN || sr == WIN;
                serving = !over;
            end else if (serving) begin
                if (tick) begin
                    serve_ticks++;
                    if (serve_ticks == SDM) serving = 0;
                end
            end else if (tick) begin
                ny = my + mdy; ndy = mdy;
                if (mdy < 0 && my == 0) begin ndy = 1; ny = 1; end
                else if (mdy > 0 && my == ROWS - SZ) begin ndy = -1; ny = my - 1; end
                if (mdx < 0 && mx == 24 && overlaps(my, int'(left_pos))) begin mdx = 1; mx = 25; end
                else if (mdx > 0 && mx + SZ == 615 && overlaps(my, int'(right_pos))) begin mdx = -1; mx = mx - 1; end
                else if (mdx < 0 && mx == 0) pending = 2;
                else if (mdx > 0 && mx == COLS - SZ) pending = 1;
                else mx += mdx;
                my = ny; mdy = ndy;
                play_ticks++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (manual) begin
            row = 9'(man_row); col = 10'(man_col);
        end else if ($urandom_range(0, 1) == 1) begin
            row = 9'(clampv(my - 1 + int'($urandom_range(0, 9)), 0, ROWS - 1));
            col = 10'(clampv(mx - 1 + int'($urandom_range(0, 9)), 0, COLS - 1));
        end else begin
            row = 9'($urandom_range(0, ROWS - 1));
            col = 10'($urandom_range(0, COLS - 1));
        end
        case (pmode)
            0: begin left_pos = 10'(lp_fix); right_pos = 10'(rp_fix); end
            1: begin
                left_pos = 10'(clampv(my + SZ - int'($urandom_range(1, 120)), 0, COLS - 1));
                right_pos = 10'(clampv(my + SZ - int'($urandom_range(1, 120)), 0, COLS - 1));
            end
            default: begin
                left_pos = 10'($urandom_range(0, 416));
                right_pos = my < 240 ? 10'd400 : 10'd0;
            end
        endcase
    end

    always @(negedge clk) begin
        chk("ball_x", ball_x, mx);
        chk("ball_y", ball_y, my);
        chk("score_left", score_left, sl);
        chk("score_right", score_right, sr);
        chk("point_pulse", point_pulse, mpp);
        chk("ball_present", ball_present,
            !over && row >= my && row < my + SZ && col >= mx && col < mx + SZ);
    end

    task automatic wait_play(input int t);
        for (int k = 0; k < 4000 && play_ticks < t; k++) @(negedge clk);
        chk("wait_play", play_ticks, t);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", ball_x, 316);
        chk("arst_y", ball_y, 236);
        chk("arst_pulse", point_pulse, 0);
        chk("arst_sl", score_left, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int tr[6] = '{236, 236, 236, 235, 243, 244};
        int tc[6] = '{316, 323, 324, 316, 316, 316};
        int te[6] = '{1, 1, 0, 0, 1, 0};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_x", ball_x, 316);
        chk("rst_y", ball_y, 236);
        chk("rst_sl", score_left, 0);
        chk("rst_sr", score_right, 0);
        manual = 1'b1;
        for (int i = 0; i < 6; i++) begin
            man_row = tr[i]; man_col = tc[i];
            @(negedge clk);
            chk("raster", ball_present, te[i]);
        end
        manual = 1'b0;
        wait_play(1);
        chk("first_x", ball_x, 317);
        chk("first_y", ball_y, 237);
        wait_play(236);
        chk("bottom_y", ball_y, 472);
        wait_play(291);
        chk("prehit_x", ball_x, 607);
        chk("prehit_y", ball_y, 417);
        wait_play(292);
        chk("hit_x", ball_x, 606);
        chk("hit_y", ball_y, 416);
        rp_fix = 0;
        pulse_reset();
        wait_play(316);
        chk("edge_x", ball_x, 632);
        chk("edge_y", ball_y, 392);
        for (int k = 0; k < 10 && score_left != 4'd1; k++) @(negedge clk);
        chk("score_sl", score_left, 1);
        chk("score_pulse", point_pulse, 1);
        chk("score_x", ball_x, 316);
        chk("score_y", ball_y, 236);
        @(negedge clk);
        chk("pulse_end", point_pulse, 0);
        wait_play(1);
        chk("serve_x", ball_x, 317);
        chk("serve_y", ball_y, 235);
        pmode = 1;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(3000, 6000)) @(negedge clk);
            for (int k = 0; k < 100 && !in_play(); k++) @(negedge clk);
            chk("in_play", in_play(), 1);
            pulse_reset();
        end
        pmode = 2;
        pulse_reset();
        for (int k = 0; k < 15000 && score_left != 4'd9; k++) @(negedge clk);
        chk("final_sl", score_left, 9);
        chk("final_sr", score_right, 0);
        repeat (1000) @(negedge clk);
        chk("frozen_x", ball_x, 316);
        chk("frozen_y", ball_y, 236);
        chk("frozen_sl", score_left, 9);
        manual = 1'b1;
        man_row = 236; man_col = 316;
        @(negedge clk);
        chk("over_present", ball_present, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
